// File: rtl/memorystage_pkg.sv
// memorystage_pkg: rv32i func codes, MEM-stage FSM states and helpers.
// Shared by memorystage, its load aligner and the bench.
package memorystage_pkg;

   localparam int BE_W = 4;

   typedef enum logic {
      MS_IDLE   = 1'b0,
      MS_ACCESS = 1'b1
   } ms_state_e;

   localparam logic [5:0] NOP   = 6'd0;
   localparam logic [5:0] ADD   = 6'd1;
   localparam logic [5:0] SUB   = 6'd2;
   localparam logic [5:0] SLL   = 6'd3;
   localparam logic [5:0] SLT   = 6'd4;
   localparam logic [5:0] SLTU  = 6'd5;
   localparam logic [5:0] XOR   = 6'd6;
   localparam logic [5:0] SRL   = 6'd7;
   localparam logic [5:0] SRA   = 6'd8;
   localparam logic [5:0] OR    = 6'd9;
   localparam logic [5:0] AND   = 6'd10;
   localparam logic [5:0] ADDI  = 6'd11;
   localparam logic [5:0] SLTI  = 6'd12;
   localparam logic [5:0] SLTIU = 6'd13;
   localparam logic [5:0] XORI  = 6'd14;
   localparam logic [5:0] ORI   = 6'd15;
   localparam logic [5:0] ANDI  = 6'd16;
   localparam logic [5:0] SLLI  = 6'd17;
   localparam logic [5:0] SRLI  = 6'd18;
   localparam logic [5:0] SRAI  = 6'd19;
   localparam logic [5:0] LUI   = 6'd20;
   localparam logic [5:0] AUIPC = 6'd21;
   localparam logic [5:0] JAL   = 6'd22;
   localparam logic [5:0] JALR  = 6'd23;
   localparam logic [5:0] BEQ   = 6'd24;
   localparam logic [5:0] BNE   = 6'd25;
   localparam logic [5:0] BLT   = 6'd26;
   localparam logic [5:0] BGE   = 6'd27;
   localparam logic [5:0] BLTU  = 6'd28;
   localparam logic [5:0] BGEU  = 6'd29;
   localparam logic [5:0] LB    = 6'd30;
   localparam logic [5:0] LH    = 6'd31;
   localparam logic [5:0] LW    = 6'd32;
   localparam logic [5:0] LBU   = 6'd33;
   localparam logic [5:0] LHU   = 6'd34;
   localparam logic [5:0] SB    = 6'd35;
   localparam logic [5:0] SH    = 6'd36;
   localparam logic [5:0] SW    = 6'd37;

   function automatic logic is_load(input logic [5:0] f);
      return f inside {LB, LH, LW, LBU, LHU};
   endfunction

   function automatic logic is_store(input logic [5:0] f);
      return f inside {SB, SH, SW};
   endfunction

   function automatic logic is_mem(input logic [5:0] f);
      return is_load(f) || is_store(f);
   endfunction

   function automatic logic is_branch(input logic [5:0] f);
      return f inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
   endfunction

   function automatic logic is_misaligned(input logic [5:0] f,
                                          input logic [1:0] a);
      return (f inside {LH, LHU, SH} && a[0]) ||
             (f inside {LW, SW} && (a != 2'b00));
   endfunction

endpackage

// File: rtl/memorystage_load_align.sv
// memorystage_load_align: picks the addressed byte/half of a load word
// and sign- or zero-extends it to the datapath width.
module memorystage_load_align
   import memorystage_pkg::*;
#(
   parameter int width = 32
) (
   input  logic [width-1:0] i_rdata,
   input  logic [1:0]       i_addr,
   input  logic [5:0]       i_func,
   output logic [width-1:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      unique case (i_addr)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_result = i_rdata;
      unique case (1'b1)
         (i_func == LB):  o_result = {{(width-8){w_byte[7]}}, w_byte};
         (i_func == LBU): o_result = {{(width-8){1'b0}}, w_byte};
         (i_func == LH):  o_result = {{(width-16){w_half[15]}}, w_half};
         (i_func == LHU): o_result = {{(width-16){1'b0}}, w_half};
         default:         o_result = i_rdata;
      endcase
   end

endmodule

// File: rtl/memorystage.sv
// memorystage: MEM pipeline stage, req/ready data port, lane steering.
// Define MEMSTAGE_MISALIGN_CHECK_EN to suppress and flag misaligned ops.
module memorystage
   import memorystage_pkg::*;
#(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] addr_in,
   input  logic [width-1:0] data_in,
   input  logic [4:0]       rd_in,
   input  logic [5:0]       func_in,
   output logic             mem_req,
   output logic             mem_we,
   output logic [width-1:0] mem_addr,
   output logic [width-1:0] mem_wdata,
   output logic [BE_W-1:0]  mem_be,
   input  logic [width-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic             stall_out,
   output logic [width-1:0] wb_data,
   output logic [4:0]       wb_rd,
   output logic             wb_we,
   output logic [5:0]       func_out,
   output logic             misalign
);

   ms_state_e        r_state;
   ms_state_e        w_state_nxt;
   logic [width-1:0] r_addr;
   logic [width-1:0] r_data;
   logic [4:0]       r_rd;
   logic [5:0]       r_func;
   logic             w_access;
   logic             w_mis_in;
   logic             w_mis_s;
   logic [width-1:0] w_ld_data;
   logic [width-1:0] w_wb_data;
   logic [4:0]       w_wb_rd;
   logic             w_wb_we;
   logic [5:0]       w_func;
   logic             w_mis;
   logic [width-1:0] r_wb_data;
   logic [4:0]       r_wb_rd;
   logic             r_wb_we;
   logic [5:0]       r_func_out;
   logic             r_misalign;

   assign w_access  = (r_state == MS_ACCESS);
   assign stall_out = w_access && !mem_ready;
   assign mem_req   = w_access;
   assign mem_addr  = {r_addr[width-1:2], 2'b00};
   assign mem_we    = w_access && is_store(r_func);

`ifdef MEMSTAGE_MISALIGN_CHECK_EN
   assign w_mis_in = is_misaligned(func_in, addr_in[1:0]);
   assign w_mis_s  = is_misaligned(r_func, r_addr[1:0]);
`else
   assign w_mis_in = 1'b0;
   assign w_mis_s  = 1'b0;
`endif

   // Byte enables are only meaningful while a request is up.
   always_comb begin
      mem_be    = '0;
      mem_wdata = r_data;
      if (w_access) begin
         unique case (1'b1)
            (r_func == SB): begin
               mem_be    = 4'b0001 << r_addr[1:0];
               mem_wdata = {4{r_data[7:0]}};
            end
            (r_func == SH): begin
               mem_be    = r_addr[1] ? 4'b1100 : 4'b0011;
               mem_wdata = {2{r_data[15:0]}};
            end
            default: mem_be = 4'b1111;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!stall_out) begin
         if (is_mem(func_in) && !w_mis_in)
            w_state_nxt = MS_ACCESS;
         else
            w_state_nxt = MS_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= MS_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr <= '0;
         r_data <= '0;
         r_rd   <= '0;
         r_func <= NOP;
      end else if (!stall_out) begin
         r_addr <= addr_in;
         r_data <= data_in;
         r_rd   <= rd_in;
         r_func <= func_in;
      end
   end

   memorystage_load_align #(
      .width (width)
   ) u_load_align (
      .i_rdata  (mem_rdata),
      .i_addr   (r_addr[1:0]),
      .i_func   (r_func),
      .o_result (w_ld_data)
   );

   // A waiting access writes a bubble into W each cycle.
   always_comb begin
      w_wb_data = '0;
      w_wb_rd   = '0;
      w_wb_we   = 1'b0;
      w_func    = NOP;
      w_mis     = 1'b0;
      if (w_access) begin
         if (mem_ready) begin
            w_func  = r_func;
            w_wb_rd = r_rd;
            if (is_load(r_func)) begin
               w_wb_data = w_ld_data;
               w_wb_we   = (r_rd != 5'd0);
            end
         end
      end else if (w_mis_s) begin
         w_mis = 1'b1;
      end else begin
         w_func    = r_func;
         w_wb_rd   = r_rd;
         w_wb_data = r_data;
         w_wb_we   = (r_rd != 5'd0) && (r_func != NOP) &&
                     !is_branch(r_func);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_data  <= '0;
         r_wb_rd    <= '0;
         r_wb_we    <= 1'b0;
         r_func_out <= NOP;
         r_misalign <= 1'b0;
      end else begin
         r_wb_data  <= w_wb_data;
         r_wb_rd    <= w_wb_rd;
         r_wb_we    <= w_wb_we;
         r_func_out <= w_func;
         r_misalign <= w_mis;
      end
   end

   assign wb_data  = r_wb_data;
   assign wb_rd    = r_wb_rd;
   assign wb_we    = r_wb_we;
   assign func_out = r_func_out;
   assign misalign = r_misalign;

endmodule

// File: tb/tb_memorystage.sv
// tb_memorystage: directed checks of ALU pass-through, stores, loads,
// stalls, back-to-back ops, reset mid-access and misaligned handling.
module tb_memorystage;
   import memorystage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr_in = '0;
   logic [31:0] data_in = '0;
   logic [4:0]  rd_in = '0;
   logic [5:0]  func_in = NOP;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b1;
   logic        stall_out;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_we;
   logic [5:0]  func_out;
   logic        misalign;

   int checks = 0;
   int errors = 0;

   memorystage #(.width(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr_in   (addr_in),
      .data_in   (data_in),
      .rd_in     (rd_in),
      .func_in   (func_in),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .stall_out (stall_out),
      .wb_data   (wb_data),
      .wb_rd     (wb_rd),
      .wb_we     (wb_we),
      .func_out  (func_out),
      .misalign  (misalign)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
      func_in = f;
      addr_in = a;
      data_in = d;
      rd_in   = rd;
   endtask

   task automatic test_reset();
      drive(NOP, 32'h0, 32'h0, 5'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({mem_req, mem_we, mem_be, stall_out, wb_we, misalign} !== 9'd0) begin
         errors++;
         $display("FAIL reset_ctl: got req=%0b we=%0b be=%b stall=%0b wbwe=%0b mis=%0b exp all 0",
                  mem_req, mem_we, mem_be, stall_out, wb_we, misalign);
      end
      checks++;
      if ({mem_addr, mem_wdata, wb_data} !== 96'd0 || wb_rd !== 5'd0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h wd=%h wbd=%h rd=%0d exp 0",
                  mem_addr, mem_wdata, wb_data, wb_rd);
      end
      checks++;
      if (func_out !== NOP) begin
         errors++;
         $display("FAIL reset_func: got %0d exp %0d", func_out, NOP);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_alu(input logic [5:0] f, input logic [31:0] d,
                           input logic [4:0] rd, input logic exp_we,
                           input string name);
      @(negedge clk);
      drive(f, 32'h0, d, rd);
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall_out !== 1'b0) begin
         errors++;
         $display("FAIL %s_req: got req=%0b stall=%0b exp 0 0", name, mem_req, stall_out);
      end
      @(negedge clk);
      drive(NOP, 32'h0, 32'h0, 5'd0);
      @(posedge clk);
      #1;
      checks++;
      if (wb_data !== d || wb_rd !== rd || wb_we !== exp_we || func_out !== f) begin
         errors++;
         $display("FAIL %s_wb: got d=%h rd=%0d we=%0b f=%0d exp d=%h rd=%0d we=%0b f=%0d",
                  name, wb_data, wb_rd, wb_we, func_out, d, rd, exp_we, f);
      end
   endtask

   task automatic test_store(input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input string name);
      @(negedge clk);
      drive(f, a, d, 5'd0);
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || stall_out !== 1'b0 ||
          mem_addr !== {a[31:2], 2'b00} || mem_be !== exp_be || mem_wdata !== exp_wd) begin
         errors++;
         $display("FAIL %s_bus: got req=%0b we=%0b st=%0b a=%h be=%b wd=%h exp 1 1 0 a=%h be=%b wd=%h",
                  name, mem_req, mem_we, stall_out, mem_addr, mem_be, mem_wdata,
                  {a[31:2], 2'b00}, exp_be, exp_wd);
      end
      @(negedge clk);
      drive(NOP, 32'h0, 32'h0, 5'd0);
      @(posedge clk);
      #1;
      checks++;
      if (wb_we !== 1'b0 || wb_data !== 32'h0 || func_out !== f || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_wb: got we=%0b d=%h f=%0d req=%0b exp 0 0 %0d 0",
                  name, wb_we, wb_data, func_out, mem_req, f);
      end
   endtask

   task automatic test_load(input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] rdat, input logic [4:0] rd,
                            input int wait_n, input logic [31:0] exp_d,
                            input logic exp_we, input string name);
      @(negedge clk);
      drive(f, a, 32'h0, rd);
      mem_rdata = rdat;
      mem_ready = (wait_n == 0);
      @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hf ||
          mem_addr !== {a[31:2], 2'b00}) begin
         errors++;
         $display("FAIL %s_bus: got req=%0b we=%0b be=%b a=%h exp 1 0 1111 a=%h",
                  name, mem_req, mem_we, mem_be, mem_addr, {a[31:2], 2'b00});
      end
      @(negedge clk);
      drive(NOP, 32'h0, 32'h0, 5'd0);
      for (int i = 0; i < wait_n; i++) begin
         checks++;
         if (stall_out !== 1'b1 || mem_addr !== {a[31:2], 2'b00}) begin
            errors++;
            $display("FAIL %s_stall%0d: got stall=%0b a=%h exp 1 a=%h",
                     name, i, stall_out, mem_addr, {a[31:2], 2'b00});
         end
         @(posedge clk);
         #1;
         checks++;
         if (wb_we !== 1'b0 || func_out !== NOP || wb_rd !== 5'd0) begin
            errors++;
            $display("FAIL %s_bubble%0d: got we=%0b f=%0d rd=%0d exp 0 %0d 0",
                     name, i, wb_we, func_out, wb_rd, NOP);
         end
         @(negedge clk);
         if (i == wait_n - 1) mem_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      checks++;
      if (wb_data !== exp_d || wb_we !== exp_we || func_out !== f ||
          stall_out !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_wb: got d=%h we=%0b f=%0d st=%0b req=%0b exp d=%h we=%0b f=%0d 0 0",
                  name, wb_data, wb_we, func_out, stall_out, mem_req, exp_d, exp_we, f);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      drive(LW, 32'h10, 32'h0, 5'd1);
      mem_rdata = 32'h1111_1111;
      mem_ready = 1'b1;
      @(negedge clk);
      drive(LW, 32'h14, 32'h0, 5'd2);
      @(posedge clk);
      #1;
      checks++;
      if (wb_data !== 32'h1111_1111 || wb_rd !== 5'd1 || wb_we !== 1'b1 ||
          mem_req !== 1'b1 || mem_addr !== 32'h14) begin
         errors++;
         $display("FAIL b2b_first: got d=%h rd=%0d we=%0b req=%0b a=%h exp 11111111 1 1 1 a=14",
                  wb_data, wb_rd, wb_we, mem_req, mem_addr);
      end
      @(negedge clk);
      drive(NOP, 32'h0, 32'h0, 5'd0);
      mem_rdata = 32'h2222_2222;
      @(posedge clk);
      #1;
      checks++;
      if (wb_data !== 32'h2222_2222 || wb_rd !== 5'd2 || wb_we !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: got d=%h rd=%0d we=%0b req=%0b exp 22222222 2 1 0",
                  wb_data, wb_rd, wb_we, mem_req);
      end
   endtask

   task automatic test_reset_during_access();
      @(negedge clk);
      drive(LW, 32'h3000, 32'h0, 5'd7);
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1 || stall_out !== 1'b1) begin
         errors++;
         $display("FAIL rstacc_pre: got req=%0b stall=%0b exp 1 1", mem_req, stall_out);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall_out !== 1'b0 || mem_be !== 4'h0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL rstacc_bus: got req=%0b stall=%0b be=%b we=%0b exp 0 0 0000 0",
                  mem_req, stall_out, mem_be, mem_we);
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || wb_data !== 32'h0 ||
          wb_rd !== 5'd0 || wb_we !== 1'b0 || func_out !== NOP || misalign !== 1'b0) begin
         errors++;
         $display("FAIL rstacc_out: got a=%h wd=%h d=%h rd=%0d we=%0b f=%0d mis=%0b exp zeros f=%0d",
                  mem_addr, mem_wdata, wb_data, wb_rd, wb_we, func_out, misalign, NOP);
      end
      @(negedge clk);
      drive(NOP, 32'h0, 32'h0, 5'd0);
      mem_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b0 || wb_we !== 1'b0) begin
         errors++;
         $display("FAIL rstacc_post: got req=%0b we=%0b exp 0 0", mem_req, wb_we);
      end
   endtask

   task automatic test_misalign();
      @(negedge clk);
      drive(LW, 32'h1001, 32'h0, 5'd4);
      mem_rdata = 32'hCAFE_F00D;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
`ifdef MEMSTAGE_MISALIGN_CHECK_EN
      checks++;
      if (mem_req !== 1'b0 || stall_out !== 1'b0) begin
         errors++;
         $display("FAIL mis_req: got req=%0b stall=%0b exp 0 0", mem_req, stall_out);
      end
      @(negedge clk);
      drive(NOP, 32'h0, 32'h0, 5'd0);
      @(posedge clk);
      #1;
      checks++;
      if (misalign !== 1'b1 || wb_we !== 1'b0 || func_out !== NOP) begin
         errors++;
         $display("FAIL mis_flag: got mis=%0b we=%0b f=%0d exp 1 0 %0d",
                  misalign, wb_we, func_out, NOP);
      end
      @(posedge clk);
      #1;
      checks++;
      if (misalign !== 1'b0) begin
         errors++;
         $display("FAIL mis_clear: got %0b exp 0", misalign);
      end
`else
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h1000 || mem_be !== 4'hf) begin
         errors++;
         $display("FAIL mis_off_bus: got req=%0b a=%h be=%b exp 1 1000 1111",
                  mem_req, mem_addr, mem_be);
      end
      @(negedge clk);
      drive(NOP, 32'h0, 32'h0, 5'd0);
      @(posedge clk);
      #1;
      checks++;
      if (wb_data !== 32'hCAFE_F00D || wb_we !== 1'b1 || misalign !== 1'b0) begin
         errors++;
         $display("FAIL mis_off_wb: got d=%h we=%0b mis=%0b exp cafef00d 1 0",
                  wb_data, wb_we, misalign);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_alu(ADDI, 32'h0000_0005, 5'd3, 1'b1, "addi");
      test_alu(LUI, 32'h1234_5000, 5'd0, 1'b0, "lui_x0");
      test_alu(JAL, 32'h0000_0104, 5'd1, 1'b1, "jal");
      test_alu(BEQ, 32'h0000_0001, 5'd9, 1'b0, "beq");
      test_store(SB, 32'h1002, 32'h0000_00AB, 4'b0100, 32'hABAB_ABAB, "sb");
      test_store(SH, 32'h2002, 32'h0000_1234, 4'b1100, 32'h1234_1234, "sh");
      test_store(SW, 32'h3000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "sw");
      test_load(LB, 32'h1003, 32'h80FF_0000, 5'd5, 3, 32'hFFFF_FF80, 1'b1, "lb");
      test_load(LBU, 32'h1003, 32'h80FF_0000, 5'd5, 3, 32'h0000_0080, 1'b1, "lbu");
      test_load(LH, 32'h2002, 32'h8001_1234, 5'd6, 0, 32'hFFFF_8001, 1'b1, "lh");
      test_load(LHU, 32'h2002, 32'h8001_1234, 5'd6, 1, 32'h0000_8001, 1'b1, "lhu");
      test_load(LB, 32'h1001, 32'h0000_7F00, 5'd8, 0, 32'h0000_007F, 1'b1, "lb_pos");
      test_load(LW, 32'h4000, 32'h1234_5678, 5'd0, 2, 32'h1234_5678, 1'b0, "lw_x0");
      test_back_to_back();
      test_reset_during_access();
      test_misalign();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
